gate_response_checker: RTL and testbench
========================================

GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 The block SHALL have parameter NUM_VECTORS, default 4, giving the number of sampled vectors per run (legal range 1..2**CNT_W-1).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the pass and fail counters.
REQ-003 Clock: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset: rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  pulse that clears results and begins a run.
REQ-006 sample_valid  input  1  the current a/b/gate outputs are a vector to check.
REQ-007 a, b  input  1 each  stimulus applied to the gate block under test.
REQ-008 and_1, or_2, not_3, not_4, nand_5, nor_6  input  1 each  responses from the gate block under test.
REQ-009 busy  output  1  high while the block is in the CHECK state.
REQ-010 done  output  1  high while the block is in the DONE state.
REQ-011 pass  output  1  done AND (fail_cnt == 0).
REQ-012 pass_cnt, fail_cnt  output  CNT_W each  counts of matching and mismatching vectors.
REQ-013 err_mask  output  6  sticky per-gate mismatch flags: bit0 and, bit1 or, bit2 not_3, bit3 not_4, bit4 nand, bit5 nor.
REQ-014 first_fail_vec  output  2  {a,b} of the first failing vector.
REQ-015 first_fail_valid  output  1  first_fail_vec holds a captured value.

Function
REQ-016 Expected values SHALL be: and = a&b, or = a|b, not_3 = ~a, not_4 = ~b, nand = ~(a&b), nor = ~(a|b).
REQ-017 The FSM SHALL have exactly three states: IDLE, CHECK and DONE.
REQ-018 Transitions SHALL be: IDLE to CHECK on start; CHECK to DONE on the edge that accepts sample number NUM_VECTORS; DONE to CHECK on start.
REQ-019 On the edge that accepts start (from IDLE or DONE), the block SHALL clear pass_cnt, fail_cnt, err_mask, first_fail_vec and first_fail_valid.
REQ-020 A sample SHALL be accepted only when state == CHECK and sample_valid == 1.
REQ-021 In IDLE and DONE, sample_valid SHALL be ignored, including when it is high in the same cycle as start.
REQ-022 On acceptance the results SHALL update at that edge and be visible the following cycle (1-cycle latency).
- match: pass_cnt increments.
- any mismatch: fail_cnt increments and err_mask |= per-gate mismatch bits.
REQ-023 start asserted while in CHECK SHALL be ignored; the run continues.
REQ-024 Both counters SHALL saturate at all-ones and never wrap.
REQ-025 An internal sample counter SHALL track accepted samples; pass_cnt + fail_cnt SHALL equal that count unless a counter has saturated.
REQ-026 done and pass SHALL hold until the next start or reset.

Reset
REQ-027 While rst_n is low, the block SHALL immediately force:
- state = IDLE;
- busy, done, pass, first_fail_valid = 0;
- pass_cnt, fail_cnt, the sample counter = 0;
- err_mask, first_fail_vec = 0.
REQ-028 Reset asserted mid-run SHALL abort the run; after release the block SHALL sit in IDLE until start.

Configuration
REQ-029 Macro GATE_CHK_FIRST_FAIL_EN SHALL control first-failure capture.
REQ-030 With GATE_CHK_FIRST_FAIL_EN defined:
- the first mismatching accepted vector of a run SHALL load first_fail_vec = {a,b} and set first_fail_valid;
- later failures in the same run SHALL not overwrite it.
REQ-031 With GATE_CHK_FIRST_FAIL_EN undefined:
- first_fail_vec and first_fail_valid SHALL be tied to 0;
- no capture registers SHALL be synthesized.

Verification
REQ-032 Correct gate model; start; vectors ab = 00, 01, 10, 11 each with sample_valid -> after the 4th: done=1, pass=1, pass_cnt=4, fail_cnt=0, err_mask=0.
REQ-033 nor_6 stuck at 0 for all four vectors -> fail at ab=00 only: fail_cnt=1, pass_cnt=3, err_mask=6'b100000, pass=0; first_fail_vec=2'b00 when the macro is defined.
REQ-034 sample_valid high in IDLE, and start with sample_valid in the same IDLE cycle -> that sample is not counted; counts after 4 further valid samples = 4 total.
REQ-035 rst_n pulsed low after 2 samples -> all outputs 0 immediately and state = IDLE; a fresh run of 4 correct vectors then gives pass_cnt=4.
REQ-036 CNT_W=2, NUM_VECTORS=3, all vectors fail -> fail_cnt=3 (no wrap); same run with NUM_VECTORS=1 -> done after 1 sample.
REQ-037 start pulsed mid-CHECK -> ignored, counts continue; start in DONE -> counters cleared and busy=1 next cycle.

Source files
------------

// File: rtl/gate_response_checker.sv
// Checks the six responses of a 2-input gate block against expected logic over a run of NUM_VECTORS samples.
// Optional first-failure capture is enabled by defining GATE_CHK_FIRST_FAIL_EN.
module gate_response_checker #(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             a,
    input  logic             b,
    input  logic             and_1,
    input  logic             or_2,
    input  logic             not_3,
    input  logic             not_4,
    input  logic             nand_5,
    input  logic             nor_6,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [5:0]       err_mask,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [5:0]       err_mask_q, err_mask_d;
    logic [5:0]       expected, observed, mismatch;
    logic             accept, clear;

    always_comb begin
        // Bit order matches err_mask: and, or, not_3, not_4, nand, nor.
        expected = {~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
        observed = {nor_6, nand_5, not_4, not_3, or_2, and_1};
        mismatch = expected ^ observed;
        accept   = sample_valid && (state_q == CHECK);
        clear    = start && (state_q != CHECK);
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        err_mask_d   = err_mask_q;

        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   if (accept && (sample_cnt_q == LAST_IDX)) state_d = DONE;
            DONE:    if (start) state_d = CHECK;
            default: state_d = IDLE;
        endcase

        if (clear) begin
            sample_cnt_d = '0;
            pass_cnt_d   = '0;
            fail_cnt_d   = '0;
            err_mask_d   = '0;
        end else if (accept) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (mismatch == 6'd0) begin
                if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end else begin
                if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
                err_mask_d = err_mask_q | mismatch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            err_mask_q   <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            err_mask_q   <= err_mask_d;
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [1:0] ff_vec_q, ff_vec_d;
    logic       ff_valid_q, ff_valid_d;

    always_comb begin
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        if (clear) begin
            ff_vec_d   = 2'b00;
            ff_valid_d = 1'b0;
        end else if (accept && (mismatch != 6'd0) && !ff_valid_q) begin
            ff_vec_d   = {a, b};
            ff_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vec_q   <= 2'b00;
            ff_valid_q <= 1'b0;
        end else begin
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
        end
    end

    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;
`else
    assign first_fail_vec   = 2'b00;
    assign first_fail_valid = 1'b0;
`endif

    assign busy     = (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign pass     = done && (fail_cnt_q == '0);
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
    assign err_mask = err_mask_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized + directed bench for gate_response_checker; three instances (default, CNT_W=2/NV=3, CNT_W=2/NV=1) share stimulus.
module tb_gate_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, sample_valid, a, b;
    logic [5:0] resp;  // {nor, nand, not_4, not_3, or, and}

    logic [2:0] busy_o, done_o, pass_o, ffv_o;
    logic [7:0] pc0, fc0;
    logic [1:0] pc1, fc1, pc2, fc2;
    logic [5:0] m0, m1, m2;
    logic [1:0] fv0, fv1, fv2;

    gate_response_checker #(.NUM_VECTORS(4), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid), .a(a), .b(b),
        .and_1(resp[0]), .or_2(resp[1]), .not_3(resp[2]), .not_4(resp[3]), .nand_5(resp[4]), .nor_6(resp[5]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .pass_cnt(pc0), .fail_cnt(fc0),
        .err_mask(m0), .first_fail_vec(fv0), .first_fail_valid(ffv_o[0]));

    gate_response_checker #(.NUM_VECTORS(3), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid), .a(a), .b(b),
        .and_1(resp[0]), .or_2(resp[1]), .not_3(resp[2]), .not_4(resp[3]), .nand_5(resp[4]), .nor_6(resp[5]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .pass_cnt(pc1), .fail_cnt(fc1),
        .err_mask(m1), .first_fail_vec(fv1), .first_fail_valid(ffv_o[1]));

    gate_response_checker #(.NUM_VECTORS(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid), .a(a), .b(b),
        .and_1(resp[0]), .or_2(resp[1]), .not_3(resp[2]), .not_4(resp[3]), .nand_5(resp[4]), .nor_6(resp[5]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .pass_cnt(pc2), .fail_cnt(fc2),
        .err_mask(m2), .first_fail_vec(fv2), .first_fail_valid(ffv_o[2]));

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: run phase per instance (0 idle, 1 running, 2 finished) plus result tallies.
    int         nv[3]   = '{4, 3, 1};
    int         cmax[3] = '{255, 3, 3};
    int         ph[3], ns[3], np[3], nf[3];
    logic [5:0] mm[3];
    logic [1:0] mfv[3];
    logic       mffv[3];

    function automatic logic [5:0] good(input logic aa, input logic bb);
        int x, y;
        x = aa; y = bb;
        return {logic'(x + y == 0), logic'(x * y == 0), logic'(y == 0), logic'(x == 0),
                logic'(x + y > 0), logic'(x * y == 1)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ph[i] = 0; ns[i] = 0; np[i] = 0; nf[i] = 0;
            mm[i] = '0; mfv[i] = '0; mffv[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [5:0] mis;
        mis = resp ^ good(a, b);
        for (int i = 0; i < 3; i++) begin
            if (ph[i] != 1) begin
                if (start) begin
                    ph[i] = 1; ns[i] = 0; np[i] = 0; nf[i] = 0;
                    mm[i] = '0; mfv[i] = '0; mffv[i] = 1'b0;
                end
            end else if (sample_valid) begin
                if (mis == 0) np[i] = (np[i] < cmax[i]) ? np[i] + 1 : cmax[i];
                else begin
                    nf[i] = (nf[i] < cmax[i]) ? nf[i] + 1 : cmax[i];
                    mm[i] = mm[i] | mis;
                    if (!mffv[i]) begin mffv[i] = 1'b1; mfv[i] = {a, b}; end
                end
                ns[i]++;
                if (ns[i] == nv[i]) ph[i] = 2;
            end
        end
    endtask

    task automatic check_all(input string where);
        logic [31:0] pc, fc, mk, fv;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin pc = 32'(pc0); fc = 32'(fc0); mk = 32'(m0); fv = 32'(fv0); end
                1:       begin pc = 32'(pc1); fc = 32'(fc1); mk = 32'(m1); fv = 32'(fv1); end
                default: begin pc = 32'(pc2); fc = 32'(fc2); mk = 32'(m2); fv = 32'(fv2); end
            endcase
            check_eq($sformatf("%s u%0d busy", where, i), 32'(busy_o[i]), 32'(ph[i] == 1));
            check_eq($sformatf("%s u%0d done", where, i), 32'(done_o[i]), 32'(ph[i] == 2));
            check_eq($sformatf("%s u%0d pass", where, i), 32'(pass_o[i]), 32'(ph[i] == 2 && nf[i] == 0));
            check_eq($sformatf("%s u%0d pass_cnt", where, i), pc, 32'(np[i]));
            check_eq($sformatf("%s u%0d fail_cnt", where, i), fc, 32'(nf[i]));
            check_eq($sformatf("%s u%0d err_mask", where, i), mk, 32'(mm[i]));
`ifdef GATE_CHK_FIRST_FAIL_EN
            check_eq($sformatf("%s u%0d ff_valid", where, i), 32'(ffv_o[i]), 32'(mffv[i]));
            check_eq($sformatf("%s u%0d ff_vec", where, i), fv, 32'(mfv[i]));
`else
            check_eq($sformatf("%s u%0d ff_valid", where, i), 32'(ffv_o[i]), 32'd0);
            check_eq($sformatf("%s u%0d ff_vec", where, i), fv, 32'd0);
`endif
        end
    endtask

    task automatic step(input string where, input logic st, input logic sv,
                        input logic aa, input logic bb, input logic [5:0] r);
        start = st; sample_valid = sv; a = aa; b = bb; resp = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all(where);
    endtask

    task automatic idle_inputs();
        start = 1'b0; sample_valid = 1'b0; a = 1'b0; b = 1'b0; resp = '0;
    endtask

    task automatic pulse_reset(input string where);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all(where);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_all({where, "_rel"});
    endtask

    initial begin
        logic [1:0] v;
        logic [5:0] flip;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2 check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

        // All four input combinations with a correct gate model
        step("start1", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            step("good", 1'b0, 1'b1, v[1], v[0], good(v[1], v[0]));
        end
        check_eq("req32 pass", 32'(pass_o[0]), 32'd1);
        check_eq("req32 pass_cnt", 32'(pc0), 32'd4);

        // nor stuck at 0: only ab=00 expects nor=1
        step("start2", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            step("norsa0", 1'b0, 1'b1, v[1], v[0], good(v[1], v[0]) & 6'b011111);
        end
        check_eq("req33 fail_cnt", 32'(fc0), 32'd1);
        check_eq("req33 err_mask", 32'(m0), 32'b100000);

        // Samples in IDLE and alongside start are ignored
        pulse_reset("rst_a");
        step("idle_sv", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        step("start_sv", 1'b1, 1'b1, 1'b0, 1'b0, good(1'b0, 1'b0));
        for (int k = 0; k < 4; k++) step("after_sv", 1'b0, 1'b1, 1'b1, 1'b1, good(1'b1, 1'b1));
        check_eq("req34 total", 32'(pc0) + 32'(fc0), 32'd4);

        // Reset mid-run aborts, then a clean run
        step("start3", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        step("mid", 1'b0, 1'b1, 1'b0, 1'b1, good(1'b0, 1'b1));
        step("mid", 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        idle_inputs();
        pulse_reset("rst_mid");
        step("stay_idle", 1'b0, 1'b1, 1'b1, 1'b0, good(1'b1, 1'b0));
        step("start4", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        // start held mid-CHECK is ignored
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            step("st_mid", k == 1, 1'b1, v[1], v[0], good(v[1], v[0]));
        end
        check_eq("req35 pass_cnt", 32'(pc0), 32'd4);
        step("start_done", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        check_eq("req37 busy", 32'(busy_o[0]), 32'd1);

        // All vectors fail on the narrow-counter instances
        for (int k = 0; k < 4; k++) step("allfail", 1'b0, 1'b1, 1'b1, 1'b0, ~good(1'b1, 1'b0));
        check_eq("req36 u1 fail_cnt", 32'(fc1), 32'd3);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                idle_inputs();
                pulse_reset("rnd_rst");
            end
            v = 2'($urandom_range(0, 3));
            flip = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            step("rnd", $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 v[1], v[0], good(v[1], v[0]) ^ flip);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
